spi_slave: RTL and testbench

SPI responder (slave) for the SoC's 8-bit register bus; the counterpart of our SPI master, so two boards, or two cores on one FPGA, can exchange bytes. It oversamples the external SCK/SS/MOSI with i_clk, shifts bytes MSB-first in mode 0 (CPOL=0, CPHA=0) with active-high SS, and presents a one-byte RX holding register and a one-byte TX buffer to the CPU through a two-address register map.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_sync.sv | 24 ++
 rtl/spi_slave.sv | 199 +++++++++++++++++++
 tb/tb_spi_slave.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants for the SPI responder: register addresses, status bit layout, TX idle fill
package spi_pkg;

   // Register map: one control/status register and one data register
   localparam logic ADDR_CTL  = 1'b0;
   localparam logic ADDR_DATA = 1'b1;

   // Status register bit positions
   localparam int RX_VALID  = 0;
   localparam int TX_EMPTY  = 1;
   localparam int OVERRUN   = 2;
   localparam int SS_ACTIVE = 3;
   localparam int IRQ_EN_RX = 4;
   localparam int IRQ_EN_TX = 5;
   localparam int BUSY      = 7;

   // Byte shifted out when the CPU has not supplied one in time
   localparam logic [7:0] TX_IDLE = 8'h00;

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - multi-flop synchronizer bringing one asynchronous SPI pin into the i_clk domain
module spi_sync #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift the pin through STAGES flops; only the last flop is used downstream
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - mode-0 SPI responder with RX holding and TX buffer registers; SPI_SLAVE_IRQ_EN adds o_irq and irq enables
module spi_slave
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_addr,
   input  logic       i_cs,
   input  logic       i_we,
   input  logic [7:0] i_dat,
   output logic [7:0] o_dat,
   input  logic       i_sck,
   input  logic       i_ss,
   input  logic       i_mosi,
   output logic       o_miso
`ifdef SPI_SLAVE_IRQ_EN
   ,
   output logic       o_irq
`endif
);

   logic       sck_s, ss_s, mosi_s;
   logic       sck_prev, ss_prev;
   logic       sck_rise, sck_fall, ss_rise, ss_fall;
   logic       ss_active;

   logic [7:0] shreg;
   logic       mosi_bit;
   logic [2:0] bit_cnt;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       overrun;
   logic [7:0] tx_buf;
   logic       tx_empty;
   logic       en_rx, en_tx;

   logic       rd_data, wr_ctl, wr_data;
   logic       ss_edge, load, shift_in, byte_done;
   logic [7:0] load_val, rx_byte, status;

   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .d       (i_sck),
      .q       (sck_s)
   );

   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .d       (i_ss),
      .q       (ss_s)
   );

   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .d       (i_mosi),
      .q       (mosi_s)
   );

   assign ss_active = ss_s;

   // Registered single-cycle edge pulses from the synchronized SCK and SS
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sck_prev <= 1'b0;
         ss_prev  <= 1'b0;
         sck_rise <= 1'b0;
         sck_fall <= 1'b0;
         ss_rise  <= 1'b0;
         ss_fall  <= 1'b0;
      end else begin
         sck_prev <= sck_s;
         ss_prev  <= ss_s;
         sck_rise <= sck_s & ~sck_prev;
         sck_fall <= ~sck_s & sck_prev;
         ss_rise  <= ss_s & ~ss_prev;
         ss_fall  <= ~ss_s & ss_prev;
      end
   end

   // Decode bus strobes and shift-engine events; SS edges take precedence over SCK edges
   always_comb begin
      rd_data   = i_cs && !i_we && (i_addr == ADDR_DATA);
      wr_ctl    = i_cs && i_we && (i_addr == ADDR_CTL);
      wr_data   = i_cs && i_we && (i_addr == ADDR_DATA);
      ss_edge   = ss_rise | ss_fall;
      load      = ss_rise | (!ss_edge && ss_active && sck_fall && (bit_cnt == 3'd0));
      shift_in  = !ss_edge && ss_active && sck_rise;
      byte_done = shift_in && (bit_cnt == 3'd7);
      load_val  = tx_empty ? TX_IDLE : tx_buf;
      // The bit sampled on this rise has not entered shreg yet, so append it here
      rx_byte   = {shreg[6:0], mosi_s};
   end

   // Shift engine: sample MOSI on SCK rise, shift it in (or reload) on the following fall
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         shreg    <= 8'h00;
         mosi_bit <= 1'b0;
         bit_cnt  <= 3'd0;
      end else if (ss_edge) begin
         bit_cnt <= 3'd0;
         if (ss_rise) begin
            shreg <= load_val;
         end
      end else if (ss_active) begin
         if (sck_rise) begin
            mosi_bit <= mosi_s;
            bit_cnt  <= bit_cnt + 3'd1;
         end else if (sck_fall) begin
            if (bit_cnt == 3'd0) begin
               shreg <= load_val;
            end else begin
               shreg <= {shreg[6:0], mosi_bit};
            end
         end
      end
   end

   // TX buffer: a load consumes the pre-write contents, a same-cycle write stays buffered
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         tx_buf   <= 8'h00;
         tx_empty <= 1'b1;
      end else begin
         if (load && !tx_empty) begin
            tx_empty <= 1'b1;
         end
         if (wr_data) begin
            tx_buf   <= i_dat;
            tx_empty <= 1'b0;
         end
      end
   end

   // RX holding register: a data read in the same cycle as byte completion frees the slot
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (wr_ctl && i_dat[OVERRUN]) begin
            overrun <= 1'b0;
         end
         if (byte_done) begin
            if (!rx_valid || rd_data) begin
               rx_data  <= rx_byte;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rd_data) begin
            rx_valid <= 1'b0;
         end
      end
   end

`ifdef SPI_SLAVE_IRQ_EN
   // Interrupt enables live in the control register; o_irq is a registered OR of enabled sources
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         en_rx <= 1'b0;
         en_tx <= 1'b0;
         o_irq <= 1'b0;
      end else begin
         if (wr_ctl) begin
            en_rx <= i_dat[IRQ_EN_RX];
            en_tx <= i_dat[IRQ_EN_TX];
         end
         o_irq <= (rx_valid & en_rx) | (tx_empty & en_tx) | overrun;
      end
   end
`else
   assign en_rx = 1'b0;
   assign en_tx = 1'b0;
`endif

   // Register read mux: status layout assembled from the live flags
   always_comb begin
      status            = 8'h00;
      status[RX_VALID]  = rx_valid;
      status[TX_EMPTY]  = tx_empty;
      status[OVERRUN]   = overrun;
      status[SS_ACTIVE] = ss_active;
      status[IRQ_EN_RX] = en_rx;
      status[IRQ_EN_TX] = en_tx;
      status[BUSY]      = (bit_cnt != 3'd0);
      o_dat             = (i_addr == ADDR_DATA) ? rx_data : status;
   end

   assign o_miso = ss_active & shreg[7];

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed and randomized bench for spi_slave against a byte-level reference model
module tb_spi_slave;

   localparam int H = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       addr, cs, we;
   logic [7:0] wdat, rdat;
   logic       sck, ss, mosi, miso;
`ifdef SPI_SLAVE_IRQ_EN
   logic       irq;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] m_rx_data, m_tx_buf, m_loaded;
   bit         m_rx_valid, m_overrun, m_tx_full, m_en_rx, m_en_tx;

   always #5 clk = ~clk;

   spi_slave #(.SYNC_STAGES(2)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .i_addr  (addr),
      .i_cs    (cs),
      .i_we    (we),
      .i_dat   (wdat),
      .o_dat   (rdat),
      .i_sck   (sck),
      .i_ss    (ss),
      .i_mosi  (mosi),
      .o_miso  (miso)
`ifdef SPI_SLAVE_IRQ_EN
      ,
      .o_irq   (irq)
`endif
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [7:0] exp_status(input bit ss_on, input bit busy);
      return {busy, 1'b0, m_en_tx, m_en_rx, ss_on, m_overrun, ~m_tx_full, m_rx_valid};
   endfunction

   task automatic m_load();
      if (m_tx_full) begin
         m_loaded  = m_tx_buf;
         m_tx_full = 1'b0;
      end else begin
         m_loaded = 8'h00;
      end
   endtask

   task automatic m_complete(input logic [7:0] b);
      if (!m_rx_valid) begin
         m_rx_data  = b;
         m_rx_valid = 1'b1;
      end else begin
         m_overrun = 1'b1;
      end
   endtask

   task automatic bus_wr(input logic a, input logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; we = 1'b1; addr = a; wdat = d;
      @(negedge clk);
      cs = 1'b0; we = 1'b0;
      if (a) begin
         m_tx_buf  = d;
         m_tx_full = 1'b1;
      end else begin
         if (d[2]) m_overrun = 1'b0;
`ifdef SPI_SLAVE_IRQ_EN
         m_en_rx = d[4];
         m_en_tx = d[5];
`endif
      end
   endtask

   task automatic bus_rd(input logic a, output logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; we = 1'b0; addr = a;
      #1 d = rdat;
      @(negedge clk);
      cs = 1'b0;
   endtask

   task automatic check_status(input string tag, input bit ss_on, input bit busy);
      logic [7:0] d;
      bus_rd(1'b0, d);
      chk(tag, d, exp_status(ss_on, busy));
   endtask

   task automatic check_data(input string tag);
      logic [7:0] d;
      bus_rd(1'b1, d);
      chk(tag, d, m_rx_data);
      m_rx_valid = 1'b0;
   endtask

   task automatic spi_begin();
      @(negedge clk);
      ss = 1'b1;
      m_load();
      cycles(H);
   endtask

   task automatic spi_byte(input string tag, input logic [7:0] tx);
      logic [7:0] got;
      for (int i = 7; i >= 0; i--) begin
         mosi = tx[i];
         cycles(H);
         got[i] = miso;
         sck = 1'b1;
         cycles(H);
         sck = 1'b0;
      end
      cycles(H);
      chk(tag, got, m_loaded);
      m_complete(tx);
      m_load();
   endtask

   task automatic spi_end();
      cycles(H);
      ss = 1'b0;
      cycles(2 * H);
   endtask

   initial begin
      logic [7:0] d;
      int         nbytes;

      rst = 1'b1; addr = 1'b0; cs = 1'b0; we = 1'b0; wdat = 8'h00;
      sck = 1'b0; ss = 1'b0; mosi = 1'b0;
      m_rx_data = 8'h00; m_tx_buf = 8'h00; m_loaded = 8'h00;
      m_rx_valid = 1'b0; m_overrun = 1'b0; m_tx_full = 1'b0;
      m_en_rx = 1'b0; m_en_tx = 1'b0;
      cycles(4);
      rst = 1'b0;
      cycles(2);

      // Reset state
      chk("reset_miso", {7'd0, miso}, 8'h00);
      bus_rd(1'b0, d);
      chk("reset_status", d, 8'h02);
      bus_rd(1'b1, d);
      chk("reset_data", d, 8'h00);

      // TX A5 while receiving 3C
      bus_wr(1'b1, 8'hA5);
      spi_begin();
      spi_byte("miso_a5", 8'h3C);
      spi_end();
      check_status("stat_after_3c", 1'b0, 1'b0);
      check_data("data_3c");
      check_status("stat_after_read", 1'b0, 1'b0);

      // Overrun: two bytes without reading
      spi_begin();
      spi_byte("miso_ovr1", 8'h11);
      spi_byte("miso_ovr2", 8'h22);
      spi_end();
      check_status("stat_overrun", 1'b0, 1'b0);
      check_data("data_first_kept");
      bus_wr(1'b0, 8'h04);
      check_status("stat_overrun_clr", 1'b0, 1'b0);

      // SS drops after four SCK edges
      @(negedge clk);
      ss = 1'b1;
      m_load();
      cycles(H);
      for (int i = 0; i < 2; i++) begin
         mosi = 1'($urandom_range(0, 1));
         cycles(H);
         sck = 1'b1;
         cycles(H);
         sck = 1'b0;
      end
      cycles(H);
      check_status("stat_partial_busy", 1'b1, 1'b1);
      ss = 1'b0;
      cycles(2 * H);
      check_status("stat_partial_drop", 1'b0, 1'b0);
      spi_begin();
      spi_byte("miso_f0", 8'hF0);
      spi_end();
      check_data("data_f0");

      // No TX write: idle fill shifted out
      spi_begin();
      spi_byte("miso_idle", 8'($urandom));
      spi_end();
      check_status("stat_no_tx", 1'b0, 1'b0);
      check_data("data_no_tx");

      // Randomized frames
      for (int f = 0; f < 6; f++) begin
         if ($urandom_range(0, 1) == 1) bus_wr(1'b1, 8'($urandom));
         spi_begin();
         nbytes = int'($urandom_range(1, 3));
         for (int k = 0; k < nbytes; k++) begin
            spi_byte("miso_rand", 8'($urandom));
            case ($urandom_range(0, 3))
               0: bus_wr(1'b1, 8'($urandom));
               1: check_data("data_rand_mid");
               2: check_status("stat_rand_mid", 1'b1, 1'b0);
               default: ;
            endcase
         end
         spi_end();
         check_status("stat_rand_end", 1'b0, 1'b0);
         check_data("data_rand_end");
         bus_wr(1'b0, 8'h04);
      end

`ifdef SPI_SLAVE_IRQ_EN
      // RX interrupt
      bus_wr(1'b0, 8'h10);
      check_status("stat_irq_en", 1'b0, 1'b0);
      cycles(2);
      chk("irq_idle", {7'd0, irq}, {7'd0, (m_rx_valid & m_en_rx) | (~m_tx_full & m_en_tx) | m_overrun});
      spi_begin();
      spi_byte("miso_irq", 8'h55);
      spi_end();
      chk("irq_rx", {7'd0, irq}, 8'h01);
      check_data("data_55");
      cycles(3);
      chk("irq_cleared", {7'd0, irq}, 8'h00);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
